// File: rtl/spi_apb_sequencer.sv
// spi_apb_sequencer
//
// APB master that programs the SPI register block and runs one byte
// transaction per accepted command. For each command it optionally writes
// CR1, CR2 and BR, then writes DR. After that it polls SR until SPIF or
// MODF is seen, and finally reads DR back. It is the only master on its
// APB segment.
//
// Ports
//   pclk, presetn      : APB clock (rising edge) and async active-low reset
//   cmd_valid/ready    : command handshake; ready only while idle
//   cmd_cfg            : 1 = write CR1/CR2/BR before DR, 0 = skip them
//   cmd_cr1/cr2/br     : configuration register values
//   cmd_txdata         : byte written to DR
//   rsp_valid          : one-cycle completion pulse
//   rsp_rxdata         : DR read value (0 on any error)
//   rsp_err            : 00 ok, 01 poll timeout, 10 wait timeout, 11 mode fault
//   busy               : high while a command is in flight, through rsp_valid
//   psel..pwdata       : APB request
//   prdata, pready     : APB response; pslverr is ignored (slave always drives it)
module spi_apb_sequencer #(
  parameter int POLL_LIMIT = 255,
  parameter int WAIT_LIMIT = 15
) (
  input  logic       pclk,
  input  logic       presetn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_cfg,
  input  logic [7:0] cmd_cr1,
  input  logic [7:0] cmd_cr2,
  input  logic [7:0] cmd_br,
  input  logic [7:0] cmd_txdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rxdata,
  output logic [1:0] rsp_err,
  output logic       busy,
  output logic       psel,
  output logic       penable,
  output logic       pwrite,
  output logic [2:0] paddr,
  output logic [7:0] pwdata,
  input  logic [7:0] prdata,
  input  logic       pready,
  input  logic       pslverr
);

  localparam logic [2:0] ADDR_CR1 = 3'b000;
  localparam logic [2:0] ADDR_CR2 = 3'b001;
  localparam logic [2:0] ADDR_BR  = 3'b010;
  localparam logic [2:0] ADDR_SR  = 3'b011;
  localparam logic [2:0] ADDR_DR  = 3'b101;

  localparam int SR_SPIF = 7;
  localparam int SR_MODF = 4;

  localparam logic [7:0] POLL_MAX = 8'(POLL_LIMIT);
  localparam logic [3:0] WAIT_MAX = 4'(WAIT_LIMIT);

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_POLL = 2'b01;
  localparam logic [1:0] ERR_WAIT = 2'b10;
  localparam logic [1:0] ERR_MODF = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_t;

  typedef enum logic [2:0] {
    ST_CR1,
    ST_CR2,
    ST_BR,
    ST_DR_WR,
    ST_SR,
    ST_DR_RD
  } step_t;

  state_t     state;
  state_t     state_nx;
  step_t      step;
  step_t      step_nx;

  logic [7:0] poll_cnt;
  logic [3:0] wait_cnt;

  logic       cfg_q;
  logic [7:0] cr1_q;
  logic [7:0] cr2_q;
  logic [7:0] br_q;
  logic [7:0] tx_q;

  logic       resp_load;
  logic [1:0] resp_err_nx;
  logic [7:0] resp_data_nx;

  logic       accept;
  logic       xfer_done;
  logic       poll_last;
  logic       wait_last;
  logic       sr_idle;
  logic       bus_active;
  logic       unused_pslverr;

  assign unused_pslverr = pslverr;

  assign accept    = (state == S_IDLE) && cmd_valid;
  assign xfer_done = (state == S_ACCESS) && pready;
  // The poll or wait that is running now is the last one the limit allows.
  assign poll_last = (poll_cnt >= (POLL_MAX - 8'd1));
  assign wait_last = (wait_cnt >= (WAIT_MAX - 4'd1));
  // An SR read that shows neither MODF nor SPIF counts as one more poll.
  assign sr_idle   = xfer_done && (step == ST_SR) &&
                     !prdata[SR_MODF] && !prdata[SR_SPIF];

  // State register
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state <= S_IDLE;
      step  <= ST_CR1;
    end else begin
      state <= state_nx;
      step  <= step_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx     = state;
    step_nx      = step;
    resp_load    = 1'b0;
    resp_err_nx  = ERR_OK;
    resp_data_nx = 8'h00;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          state_nx = S_SETUP;
          step_nx  = cmd_cfg ? ST_CR1 : ST_DR_WR;
        end
      end
      S_SETUP: begin
        state_nx = S_ACCESS;
      end
      S_ACCESS: begin
        if (pready) begin
          // By default the sequencer moves on to the next SETUP. The cases
          // below override this when the command ends here.
          state_nx = S_SETUP;
          case (step)
            ST_CR1:   step_nx = ST_CR2;
            ST_CR2:   step_nx = ST_BR;
            ST_BR:    step_nx = ST_DR_WR;
            ST_DR_WR: step_nx = ST_SR;
            ST_SR: begin
              // MODF wins over SPIF when both bits are set.
              if (prdata[SR_MODF]) begin
                state_nx    = S_RESP;
                resp_load   = 1'b1;
                resp_err_nx = ERR_MODF;
              end else if (prdata[SR_SPIF]) begin
                step_nx = ST_DR_RD;
              end else if (poll_last) begin
                state_nx    = S_RESP;
                resp_load   = 1'b1;
                resp_err_nx = ERR_POLL;
              end
            end
            ST_DR_RD: begin
              state_nx     = S_RESP;
              resp_load    = 1'b1;
              resp_err_nx  = ERR_OK;
              resp_data_nx = prdata;
            end
            default: begin
              state_nx = S_IDLE;
            end
          endcase
        end else if (wait_last) begin
          state_nx    = S_RESP;
          resp_load   = 1'b1;
          resp_err_nx = ERR_WAIT;
        end
      end
      S_RESP: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    bus_active = (state == S_SETUP) || (state == S_ACCESS);
    cmd_ready  = (state == S_IDLE);
    busy       = (state != S_IDLE);
    rsp_valid  = (state == S_RESP);
    psel       = bus_active;
    penable    = (state == S_ACCESS);
    pwrite     = 1'b0;
    paddr      = 3'b000;
    pwdata     = 8'h00;
    // The address and data come only from the step register and the latched
    // command. They therefore stay stable from SETUP through every ACCESS
    // wait cycle.
    if (bus_active) begin
      case (step)
        ST_CR1: begin
          pwrite = 1'b1;
          paddr  = ADDR_CR1;
          pwdata = cr1_q;
        end
        ST_CR2: begin
          pwrite = 1'b1;
          paddr  = ADDR_CR2;
          pwdata = cr2_q;
        end
        ST_BR: begin
          pwrite = 1'b1;
          paddr  = ADDR_BR;
          pwdata = br_q;
        end
        ST_DR_WR: begin
          pwrite = 1'b1;
          paddr  = ADDR_DR;
          pwdata = tx_q;
        end
        ST_SR: begin
          paddr = ADDR_SR;
        end
        ST_DR_RD: begin
          paddr = ADDR_DR;
        end
        default: begin
          paddr = 3'b000;
        end
      endcase
    end
  end

  // Poll/wait counters and the response registers
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      poll_cnt   <= 8'h00;
      wait_cnt   <= 4'h0;
      rsp_rxdata <= 8'h00;
      rsp_err    <= ERR_OK;
    end else begin
      if (accept) begin
        poll_cnt <= 8'h00;
      end else if (sr_idle && (poll_cnt != POLL_MAX)) begin
        poll_cnt <= poll_cnt + 8'd1;
      end

      if (state == S_SETUP) begin
        wait_cnt <= 4'h0;
      end else if ((state == S_ACCESS) && !pready && (wait_cnt != WAIT_MAX)) begin
        wait_cnt <= wait_cnt + 4'd1;
      end

      if (resp_load) begin
        rsp_rxdata <= resp_data_nx;
        rsp_err    <= resp_err_nx;
      end
    end
  end

  // Command capture: these are pure data and are only read after an accept
  // has loaded them.
  always_ff @(posedge pclk) begin
    if (accept) begin
      cfg_q <= cmd_cfg;
      cr1_q <= cmd_cr1;
      cr2_q <= cmd_cr2;
      br_q  <= cmd_br;
      tx_q  <= cmd_txdata;
    end
  end

  // The configuration flag only selects the first step at accept time. It
  // is kept with the other command fields so the captured command is
  // complete.
  logic unused_cfg_q;
  assign unused_cfg_q = cfg_q;

endmodule

// File: doc/spi_apb_sequencer.md
Name: spi_apb_sequencer

Overview:
- APB master that configures the SPI register block and runs one full byte transaction per accepted command.
- Per command: optionally writes CR1, CR2 and BR, writes DR, polls SR until SPIF or MODF, then reads DR.
- Sits between the system command source (CPU shim or test harness) and the SPI APB slave port; it is the only master on that APB segment.

Parameters:
- POLL_LIMIT, 255: max SR reads per command before poll timeout (1..255, 8-bit counter).
- WAIT_LIMIT, 15: max consecutive ACCESS cycles with pready=0 before wait timeout (1..15, 4-bit counter).

Ports:
- pclk in 1: APB clock; all logic on rising edge.
- presetn in 1: asynchronous, active-low reset.
- cmd_valid in 1: command request.
- cmd_ready out 1: high only in IDLE.
- cmd_cfg in 1: 1 = write CR1/CR2/BR before DR; 0 = skip them.
- cmd_cr1 in 8: CR1 value.
- cmd_cr2 in 8: CR2 value.
- cmd_br in 8: BR value.
- cmd_txdata in 8: byte written to DR.
- rsp_valid out 1: one-cycle completion pulse.
- rsp_rxdata out 8: DR read value; 0 on error.
- rsp_err out 2: 00 ok, 01 poll timeout, 10 wait timeout, 11 mode fault.
- busy out 1: high from accept until the rsp_valid cycle, inclusive.
- psel out 1, penable out 1, pwrite out 1, paddr out 3, pwdata out 8: APB request.
- prdata in 8, pready in 1, pslverr in 1: APB response. pslverr is not interpreted; the slave asserts it in every access phase.

Behaviour:
- Register map: CR1=3'b000, CR2=3'b001, BR=3'b010, SR=3'b011, DR=3'b101. SR bit7=SPIF, bit4=MODF.
- Reset values: cmd_ready=1, rsp_valid=0, rsp_rxdata=0, rsp_err=0, busy=0, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0. Internal state is IDLE and all counters are 0.
- Reset asserted mid-transfer aborts immediately: psel and penable drop asynchronously and no response is issued.
- Accept: cmd_valid & cmd_ready on edge N latches all cmd_* fields. cmd_ready is low from N+1 until the cycle after rsp_valid.
- Step list: cmd_cfg=1 gives WR_CR1, WR_CR2, WR_BR, WR_DR, RD_SR (repeated), RD_DR. cmd_cfg=0 gives WR_DR, RD_SR (repeated), RD_DR.
- Each step is one APB transfer:
  - SETUP, 1 cycle: psel=1, penable=0; paddr, pwrite and pwdata driven.
  - ACCESS: psel=1, penable=1; held until pready=1. paddr, pwrite and pwdata stay stable throughout.
- Transfers run back-to-back: after an ACCESS that completes with pready, the next step's SETUP follows immediately with psel kept high. The first SETUP is cycle N+1.
- Zero-wait latency:
  - cmd_cfg=1: 12 cycles of APB traffic with one SR poll; rsp_valid at N+13.
  - cmd_cfg=0: 6 cycles of traffic; rsp_valid at N+7.
- Reads sample prdata on the ACCESS cycle where pready=1.
- RD_SR results, evaluated in priority order:
  1. MODF=1: end with err 11 and no DR read.
  2. SPIF=1: go to RD_DR.
  3. Otherwise increment poll_cnt. If poll_cnt reaches POLL_LIMIT, end with err 01; else issue another RD_SR.
- Wait timeout: wait_cnt counts ACCESS cycles with pready=0 and clears at each new SETUP. When it reaches WAIT_LIMIT, drop psel and penable on the next edge and end with err 10.
- End of command:
  - Cycle after the final ACCESS, or after an abort: psel=0, penable=0, rsp_valid=1 for exactly 1 cycle.
  - rsp_rxdata = DR value if err=00, else 0. rsp_rxdata and rsp_err hold until the next response.
  - State returns to IDLE; cmd_ready=1 the following cycle.
- cmd_valid while busy is ignored (no queueing). A command offered in the same cycle cmd_ready rises is accepted.
- Transfer FSM states: IDLE, SETUP, ACCESS, RESP. A step sequencer register selects the address and data per step.
- poll_cnt saturates at POLL_LIMIT and clears on accept.

Test Plan:
- Zero-wait, cmd_cfg=1, CR1=8'h50, CR2=8'h02, BR=8'h23, tx=8'hA5; slave SR=8'h80 on the first poll; DR read returns 8'h3C -> APB writes to addresses 0,1,2,5 with data 50,02,23,A5; one read of 3; read of 5; rsp_valid at N+13 with rxdata=3C, err=00.
- cmd_cfg=0, tx=8'h11; SR returns 8'h00 three times then 8'h80; DR=8'h77 -> no CR writes; four SR reads; rsp rxdata=77, err=00.
- SR never shows SPIF, POLL_LIMIT=4 -> exactly 4 SR reads, no DR read, rsp_err=01, rxdata=00.
- pready held low in the WR_DR ACCESS phase, WAIT_LIMIT=15 -> psel drops after 15 ACCESS cycles; rsp_err=10.
- SR returns 8'h90 (SPIF and MODF both set) -> no DR read; rsp_err=11. Then a second command is accepted in the cycle after cmd_ready rises.
- presetn pulsed low during the BR ACCESS phase -> psel, penable and busy go 0 asynchronously; no rsp_valid; next command restarts cleanly from WR_CR1.
